// File: rtl/proj_sweep_sig.sv
// ============================================================================
// Module   : proj_sweep_sig
// Purpose  : Exhaustive 2^NIN input sweep of one projected PROM output bit,
//            with ones count and CRC signature over the responses.
//            Optional macro SWEEP_PIPE_EN registers y before compaction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proj_sweep_sig #(
  parameter int               NIN      = 9,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [NIN-1:0]   x,
  input  logic             y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NIN:0]     ones,
  output logic [SIG_W-1:0] sig
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [NIN-1:0] c_cnt_last = '1;
  localparam logic [NIN-1:0] c_cnt_one  = {{(NIN-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_take;
  logic             w_s;
  logic             w_fb;
  logic [NIN-1:0]   r_cnt;
  logic [NIN:0]     r_ones;
  logic [SIG_W-1:0] r_sig;
  logic [NIN:0]     w_ones_nxt;
  logic [SIG_W-1:0] w_sig_nxt;

`ifdef SWEEP_PIPE_EN
  // r_y_v marks that r_y_q holds the response to a vector of this sweep.
  logic r_y_q;
  logic r_y_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= 1'b0;
      r_y_v <= 1'b0;
    end else begin
      r_y_q <= y;
      r_y_v <= (r_state == SWEEP);
    end
  end

  assign w_s    = r_y_q;
  assign w_take = ((r_state == SWEEP) && r_y_v) || (r_state == DRAIN);
`else
  assign w_s    = y;
  assign w_take = (r_state == SWEEP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        if (r_cnt == c_cnt_last) begin
`ifdef SWEEP_PIPE_EN
          w_state_nxt = DRAIN;
`else
          w_state_nxt = HOLD;
`endif
        end
      end
      DRAIN: w_state_nxt = HOLD;
      HOLD: begin
        // Accept cycle doubles as a start window for back-to-back sweeps.
        if (res_ready) begin
          if (start) begin
            w_load      = 1'b1;
            w_state_nxt = SWEEP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_fb       = r_sig[SIG_W-1] ^ w_s;
  assign w_sig_nxt  = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? SIG_POLY : {SIG_W{1'b0}});
  assign w_ones_nxt = r_ones + {{NIN{1'b0}}, w_s};

  // cnt wraps back to zero on the last vector, so x idles at 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ones <= '0;
      r_sig  <= SIG_SEED;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_ones <= '0;
      r_sig  <= SIG_SEED;
    end else begin
      if (r_state == SWEEP) r_cnt <= r_cnt + c_cnt_one;
      if (w_take) begin
        r_ones <= w_ones_nxt;
        r_sig  <= w_sig_nxt;
      end
    end
  end

  assign x         = r_cnt;
  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == HOLD);
  assign ones      = r_ones;
  assign sig       = r_sig;

endmodule

`default_nettype wire

// File: tb/tb_proj_sweep_sig.sv
// ============================================================================
// Module   : tb_proj_sweep_sig
// Purpose  : Scoreboard bench for proj_sweep_sig with a behavioural function
//            and CRC model; latency follows the SWEEP_PIPE_EN build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proj_sweep_sig;

`ifdef SWEEP_PIPE_EN
  localparam int LAT = 514;
`else
  localparam int LAT = 513;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       res_ready = 1'b0;
  logic       y;
  logic       busy;
  logic       res_valid;
  logic [8:0] x;
  logic [9:0] ones;
  logic [15:0] sig;

  int   mode = 0;
  logic lut [512];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_v = 1'b0;

  typedef struct {
    logic [9:0]  ones;
    logic [15:0] sig;
    int          c0;
  } exp_t;
  exp_t sb [$];

  proj_sweep_sig dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .x         (x),
    .y         (y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ones      (ones),
    .sig       (sig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y = (mode == 0) ? 1'b0 :
             (mode == 1) ? x[0] :
             (mode == 2) ? 1'b1 :
             (mode == 3) ? lut[x] : ^x;

  function automatic logic fy(input logic [8:0] v);
    case (mode)
      0:       return 1'b0;
      1:       return v[0];
      2:       return 1'b1;
      3:       return lut[v];
      default: return ^v;
    endcase
  endfunction

  // Reference: popcount of the truth table and CRC-16/0x1021 over it, seed FFFF.
  function automatic exp_t model(input int c0);
    exp_t e;
    logic b;
    e.ones = '0;
    e.sig  = 16'hFFFF;
    e.c0   = c0;
    for (int i = 0; i < 512; i++) begin
      b = fy(9'(i));
      e.ones = e.ones + 10'(b);
      if (e.sig[15] ^ b) e.sig = {e.sig[14:0], 1'b0} ^ 16'h1021;
      else               e.sig = {e.sig[14:0], 1'b0};
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start();
    start = 1'b1;
    sb.push_back(model(cyc));
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 700 && !res_valid; k++) begin
      start = (k == 100);
      step();
    end
    start = 1'b0;
    check("valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom_range(0, 1));
      step();
      check("hold_valid", 32'(res_valid), 32'd1);
    end
    start = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(res_valid), 32'd0);
    check("idle_x", 32'(x), 32'd0);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          if (!prev_v) check("latency", 32'(cyc - sb[0].c0), 32'(LAT));
          check("ones", 32'(ones), 32'(sb[0].ones));
          check("sig", 32'(sig), 32'(sb[0].sig));
          if (res_ready) void'(sb.pop_front());
        end
      end
      prev_v = res_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (lut[i]) lut[i] = 1'($urandom_range(0, 1));
    #12;
    check("rst_x", 32'(x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_sig", 32'(sig), 32'hFFFF);
    step();
    rst_n = 1'b1;
    step();

    mode = 0; issue_start(); wait_valid(); hold(20); accept();
    mode = 1; issue_start(); wait_valid(); hold(3);  accept();
    mode = 2; issue_start(); wait_valid(); hold(20); accept();

    // Back-to-back: accept and restart in the same cycle.
    mode = 3;
    foreach (lut[i]) lut[i] = 1'($urandom_range(0, 1));
    issue_start(); wait_valid(); hold(5);
    res_ready = 1'b1;
    issue_start();
    res_ready = 1'b0;
    check("b2b_x", 32'(x), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid", 32'(res_valid), 32'd0);
    check("b2b_ones", 32'(ones), 32'd0);
    wait_valid(); hold(2); accept();

    // Reset mid-sweep aborts without presenting a partial result.
    mode = 4;
    issue_start();
    for (int k = 0; k < 400 && x != 9'd200; k++) step();
    check("reach_200", 32'(x), 32'd200);
    rst_n = 1'b0;
    #1;
    check("abort_x", 32'(x), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_ones", 32'(ones), 32'd0);
    check("abort_sig", 32'(sig), 32'hFFFF);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    issue_start(); wait_valid(); hold(1); accept();

    mode = 3;
    foreach (lut[i]) lut[i] = 1'($urandom_range(0, 1));
    issue_start(); wait_valid(); hold(0); accept();

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proj_sweep_sig.md
# proj_sweep_sig

Exhaustive-sweep driver and result compactor for one projected PROM output bit. It sits directly around the combinational projected-function stage. Upstream, it drives every 9-bit input vector x0..x8 in ascending order. Downstream, it samples the single output y0 for each vector, counts the ones, and folds the responses into a CRC-style signature. Results are handed to the collection logic over a valid/ready handshake.

## Interface
- NIN, 9, number of function inputs; the sweep length is 2^NIN.
- SIG_W, 16, signature width.
- SIG_POLY, 16'h1021, feedback polynomial for the signature register.
- SIG_SEED, 16'hFFFF, signature value loaded at sweep start.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  sweep request; sampled only in IDLE, or in HOLD on the same cycle the handshake completes.
- busy  out  1  high in SWEEP, DRAIN and HOLD.
- x  out  NIN  vector driven to the function; x[0]=x0 … x[8]=x8; registered.
- y  in  1  function output y0, combinational from x.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- ones  out  NIN+1  count of vectors with y=1; range 0..2^NIN.
- sig  out  SIG_W  final signature.

## Operation
- Reset: state IDLE; x=0, busy=0, res_valid=0, ones=0, sig=SIG_SEED.
- IDLE: x held at 0. On start=1, the block loads cnt=0, ones=0 and sig=SIG_SEED, and goes to SWEEP.
- SWEEP: x=cnt. Each cycle the block takes one sample s.
  - Without the macro, s is y from the current x.
  - s=1 increments ones.
  - Signature update: fb = sig[SIG_W-1]^s; sig = {sig[SIG_W-2:0],1'b0} ^ (fb ? SIG_POLY : 0).
  - cnt increments. When cnt=2^NIN-1 is sampled, the next state is HOLD (no macro) or DRAIN (macro).
- DRAIN (macro only): one cycle, absorbs the last pipelined sample, then goes to HOLD.
- HOLD: res_valid=1; ones and sig are stable.
  - On res_valid&res_ready, the next state is IDLE.
  - If start=1 on that same cycle, the next state is SWEEP directly, with counters reloaded.
- start outside IDLE or the HOLD-accept cycle is ignored; there is no queuing.
- cnt is NIN bits wide and its wrap is the terminal condition. ones is NIN+1 bits wide and never saturates, since its maximum is 2^NIN.
- Reset asserted mid-sweep or in HOLD aborts immediately to the reset values. A partial result is never presented.

## Timing
- x changes only on the clock edge. The function must settle within one cycle from registered x.
- Without macro: start is sampled at cycle 0.
  - x=0 in cycle 1, x=2^NIN-1 in cycle 2^NIN.
  - res_valid=1 from cycle 2^NIN+1.
  - Start-to-valid latency is 2^NIN+1 cycles (513 at default).
- With macro: latency is 2^NIN+2 (514). Sample i is the y registered while x=i.
- res_valid stays high until accepted. ones and sig do not change while res_valid=1.
- busy rises the cycle after start is accepted and falls the cycle after the handshake, unless a back-to-back start is taken.

## Configuration
- SWEEP_PIPE_EN defined: y is registered before the counter and signature update, adding the DRAIN state and one cycle of latency. Use this when the projected function sits on a long path.
- Not defined: y is consumed in the same cycle as x and there is no DRAIN state.
- ones and sig are identical in both builds for the same function.

## Test plan
- y tied 0, start pulse -> res_valid at cycle 513 (514 with macro); ones=0; sig equals the bench CRC model over 512 zero bits from 16'hFFFF.
- y=x[0] -> ones=256; y tied 1 -> ones=512 (10'h200); sig matches the model in each case.
- res_ready held low 20 cycles after valid -> res_valid, ones and sig stable throughout; start pulses during the hold are ignored.
- res_ready=1 and start=1 in the same cycle -> the next cycle is SWEEP with x=0 and ones cleared; the second result is identical to the first.
- rst_n asserted at cnt=200 -> next edge gives x=0, busy=0, res_valid=0; a new start gives a full, correct 513-cycle sweep.
- Build with and without SWEEP_PIPE_EN, using the bench model of the projected function -> identical ones and sig; latencies of 514 and 513 respectively.
